// File: rtl/stella_race.sv
// StellaRace pixel-colour generator: owns the game state (player, obstacles,
// starfield scroll, game-over latch) and returns a registered RGB444 colour per pixel.
module stella_race #(
   parameter int unsigned PLAYER_STEP = 4,
   parameter int unsigned OBST_SPEED  = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [8:0]  y,
   input  logic [9:0]  x,
   input  logic        movel,
   input  logic        mover,
   output logic [11:0] color
);

   localparam int unsigned XW       = 10;
   localparam int unsigned YW       = 9;
   localparam int unsigned NOBS     = 4;
   localparam int unsigned SZ       = 32;
   localparam int unsigned PLAYER_Y = 448;
   localparam int unsigned X_MAX    = 608;
   localparam int unsigned H_VIS    = 640;
   localparam int unsigned V_VIS    = 480;

   logic [XW-1:0] player_x;
   logic [XW-1:0] ox [NOBS];
   logic [YW-1:0] oy [NOBS];
   logic [7:0]    scroll;
   logic          game_over;
   logic [15:0]   lfsr;
   logic          eof_d;

   logic          eof_c;
   logic          tick_c;
   logic          hit_c;
   logic [15:0]   lfsr_nx_c;
   logic [XW-1:0] player_nx_c;
   logic          in_player_c;
   logic          in_obs_c;
   logic          star_c;
   logic [YW-1:0] star_y_c;
   logic [11:0]   pix_c;

   // Frame tick fires once per entry into the last visible pixel.
   assign eof_c  = (x == XW'(H_VIS - 1)) && (y == YW'(V_VIS - 1));
   assign tick_c = eof_c && !eof_d;

   assign lfsr_nx_c = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   // Collision test and steering, both on pre-update positions.
   always_comb begin
      hit_c = 1'b0;
      for (int k = 0; k < int'(NOBS); k++) begin
         if ((11'(player_x) < 11'(ox[k]) + 11'(SZ)) &&
             (11'(ox[k]) < 11'(player_x) + 11'(SZ)) &&
             (11'(oy[k]) + 11'(SZ) > 11'(PLAYER_Y)) &&
             (11'(oy[k]) < 11'(PLAYER_Y + 16)))
            hit_c = 1'b1;
      end
      player_nx_c = player_x;
      if (movel && !mover)
         player_nx_c = (player_x < XW'(PLAYER_STEP)) ? '0 : player_x - XW'(PLAYER_STEP);
      else if (mover && !movel)
         player_nx_c = (player_x > XW'(X_MAX - PLAYER_STEP)) ? XW'(X_MAX)
                                                             : player_x + XW'(PLAYER_STEP);
   end

   // Pixel colour by priority: off-screen, player, obstacle, star, background.
   always_comb begin
      in_player_c = (x >= player_x) && (11'(x) < 11'(player_x) + 11'(SZ)) &&
                    (y >= YW'(PLAYER_Y)) && (y < YW'(PLAYER_Y + 16));
      in_obs_c = 1'b0;
      for (int k = 0; k < int'(NOBS); k++) begin
         if ((x >= ox[k]) && (11'(x) < 11'(ox[k]) + 11'(SZ)) &&
             (y >= oy[k]) && (10'(y) < 10'(oy[k]) + 10'(SZ)))
            in_obs_c = 1'b1;
      end
      star_y_c = y + YW'(scroll);
      star_c   = (x[4:0] == 5'd7) && (star_y_c[4:0] == 5'd3);
      if ((x >= XW'(H_VIS)) || (y >= YW'(V_VIS)))
         pix_c = 12'h000;
      else if (in_player_c)
         pix_c = game_over ? 12'hFFF : 12'h0FF;
      else if (in_obs_c)
         pix_c = 12'hF00;
      else if (star_c)
         pix_c = 12'h888;
      else
         pix_c = game_over ? 12'h400 : 12'h000;
   end

   // eof_d resets high so a tick needs a fresh entry into the last pixel after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color     <= 12'h000;
         eof_d     <= 1'b1;
         player_x  <= XW'(304);
         scroll    <= '0;
         game_over <= 1'b0;
         lfsr      <= LFSR_SEED;
         for (int k = 0; k < int'(NOBS); k++) begin
            ox[k] <= XW'(64 + 160 * k);
            oy[k] <= YW'(120 * k);
         end
      end else begin
         color <= pix_c;
         eof_d <= eof_c;
         if (tick_c && !game_over) begin
            if (hit_c) begin
               game_over <= 1'b1;
            end else begin
               lfsr     <= lfsr_nx_c;
               scroll   <= scroll + 8'd1;
               player_x <= player_nx_c;
               for (int k = 0; k < int'(NOBS); k++) begin
                  if (10'(oy[k]) + 10'(OBST_SPEED) >= 10'(V_VIS)) begin
                     oy[k] <= '0;
                     ox[k] <= 10'(lfsr[8:0]) + 10'd48;
                  end else begin
                     oy[k] <= oy[k] + YW'(OBST_SPEED);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stella_race.sv
// Scoreboard bench for stella_race: a game-level reference model predicts each
// pixel colour; a monitor compares the DUT output one cycle later.
module tb_stella_race;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  y;
   logic [9:0]  x;
   logic        movel;
   logic        mover;
   logic [11:0] color;

   always #5 clk = ~clk;

   stella_race dut (
      .clk   (clk),
      .rst_n (rst_n),
      .y     (y),
      .x     (x),
      .movel (movel),
      .mover (mover),
      .color (color)
   );

   typedef struct {
      logic [11:0] exp;
      int          px;
      int          py;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference game state as plain integers.
   int m_px, m_scroll, m_lfsr, m_ticks;
   int m_ox [4];
   int m_oy [4];
   bit m_go, m_eofd;
   bit rst_req;

   task automatic model_reset();
      m_px = 304; m_scroll = 0; m_lfsr = 16'hACE1; m_go = 0; m_eofd = 1; m_ticks = 0;
      for (int k = 0; k < 4; k++) begin
         m_ox[k] = 64 + 160 * k;
         m_oy[k] = 120 * k;
      end
   endtask

   function automatic logic [11:0] ref_pix(int px, int py);
      if (px >= 640 || py >= 480) return 12'h000;
      if (px >= m_px && px < m_px + 32 && py >= 448 && py <= 463)
         return m_go ? 12'hFFF : 12'h0FF;
      for (int k = 0; k < 4; k++)
         if (px >= m_ox[k] && px < m_ox[k] + 32 && py >= m_oy[k] && py < m_oy[k] + 32)
            return 12'hF00;
      if (px % 32 == 7 && (py + m_scroll) % 32 == 3) return 12'h888;
      return m_go ? 12'h400 : 12'h000;
   endfunction

   task automatic model_tick(bit ml, bit mr);
      bit hit = 0;
      int nb;
      m_ticks++;
      if (m_go) return;
      for (int k = 0; k < 4; k++)
         if (m_px < m_ox[k] + 32 && m_ox[k] < m_px + 32 && 448 < m_oy[k] + 32 && m_oy[k] < 464)
            hit = 1;
      if (hit) begin
         m_go = 1;
         return;
      end
      for (int k = 0; k < 4; k++) begin
         if (m_oy[k] + 2 >= 480) begin
            m_oy[k] = 0;
            m_ox[k] = (m_lfsr % 512) + 48;
         end else begin
            m_oy[k] = m_oy[k] + 2;
         end
      end
      nb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) | nb) % 65536;
      m_scroll = (m_scroll + 1) % 256;
      if (ml && !mr) m_px = (m_px < 4) ? 0 : m_px - 4;
      else if (mr && !ml) m_px = (m_px + 4 > 608) ? 608 : m_px + 4;
   endtask

   // One cycle of stimulus; expectation is taken from pre-edge model state.
   task automatic drive(int px, int py, bit ml, bit mr);
      exp_t e;
      bit   eof;
      @(negedge clk);
      rst_n = !rst_req;
      if (rst_req) model_reset();
      x = 10'(px); y = 9'(py); movel = ml; mover = mr;
      e.px = px; e.py = py;
      e.exp = rst_req ? 12'h000 : ref_pix(px, py);
      sb.push_back(e);
      if (!rst_req) begin
         eof = (px == 639 && py == 479);
         if (eof && !m_eofd) model_tick(ml, mr);
         m_eofd = eof;
      end
   endtask

   task automatic drive_rand(bit ml, bit mr);
      int px, py;
      px = $urandom_range(0, 679);
      py = ($urandom_range(0, 1) == 1) ? $urandom_range(440, 470) : $urandom_range(0, 499);
      if (px == 639 && py == 479) px = 638;
      drive(px, py, ml, mr);
   endtask

   task automatic frame(bit ml, bit mr, int nsamp);
      for (int i = 0; i < nsamp; i++) drive_rand(ml, mr);
      drive(639, 479, ml, mr);
      drive(0, 0, ml, mr);
   endtask

   task automatic do_reset(int n);
      rst_req = 1;
      for (int i = 0; i < n; i++) drive_rand(0, 0);
      rst_req = 0;
   endtask

   // Monitor: one expectation per cycle, compared just after the active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (color !== e.exp) begin
            bad++;
            $display("FAIL color(%0d,%0d) got=%h exp=%h", e.px, e.py, color, e.exp);
         end
      end
   end

   initial begin
      rst_req = 1; rst_n = 1'b0; x = '0; y = '0; movel = 0; mover = 0;
      model_reset();
      do_reset(4);

      drive(320, 455, 0, 0);
      drive(70, 10, 0, 0);
      drive(7, 3, 0, 0);
      drive(8, 3, 0, 0);
      drive(700, 10, 0, 0);
      drive(100, 500, 0, 0);

      for (int i = 0; i < 10; i++) drive(639, 479, 1, 0);
      drive(300, 455, 0, 0);
      drive(299, 455, 0, 0);

      for (int i = 0; i < 80; i++) frame(1, 0, 2);
      drive(0, 448, 0, 0);
      drive(32, 448, 0, 0);
      for (int i = 0; i < 160; i++) frame(0, 1, 2);
      drive(639, 463, 0, 0);
      for (int i = 0; i < 5; i++) frame(1, 1, 2);
      drive(639, 463, 0, 0);
      drive(576, 463, 0, 0);

      // Fresh game: steer right 20 frames, then idle until the crash.
      do_reset(3);
      frame(0, 1, 0);
      drive(64, 1, 0, 0);
      drive(64, 2, 0, 0);
      drive(64, 33, 0, 0);
      drive(64, 34, 0, 0);
      for (int i = 0; i < 19; i++) frame(0, 1, 2);
      for (int i = 0; i < 120 && !m_go; i++) begin
         frame(0, 0, 3);
         if (m_ticks == 60) begin
            drive(m_ox[3] + 5, 1, 0, 0);
            drive(m_ox[3] + 31, 31, 0, 0);
            drive(m_ox[3] + 32, 31, 0, 0);
         end
      end
      drive(384, 455, 0, 0);
      drive(10, 300, 0, 0);
      for (int i = 0; i < 4; i++) frame(1, 0, 4);
      drive(384, 455, 0, 0);
      drive(380, 455, 0, 0);

      do_reset(3);
      drive(10, 300, 0, 0);

      for (int i = 0; i < 200; i++) drive_rand($urandom_range(0, 1), $urandom_range(0, 1));

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
